// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write controller.
package regfile_pkg;
    localparam int NREGS   = 32;
    localparam int RADDR_W = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr names the requester favoured on a tie.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       ptr,
    output logic [1:0] grant
);
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: clears registers 1..31 after reset or clr,
// then serialises writes from two requesters with round-robin arbitration.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int n = 8
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               clr,
    input  logic               req0,
    input  logic               req1,
    input  logic [RADDR_W-1:0] addr0,
    input  logic [RADDR_W-1:0] addr1,
    input  logic [n-1:0]       data0,
    input  logic [n-1:0]       data1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               rf_w,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [n-1:0]       rf_wdata
);
    state_e             state_q, state_d;
    logic [RADDR_W-1:0] cnt_q, cnt_d;
    logic               ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               rf_w_q, rf_w_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [n-1:0]       wdata_q, wdata_d;

    logic [1:0]         eligible;
    logic [1:0]         grant;
    logic [RADDR_W-1:0] sel_addr;
    logic [n-1:0]       sel_data;

    // A requester just granted must drop out for one cycle so a held req
    // is not taken twice.
    assign eligible = {req1 & ~gnt1_q, req0 & ~gnt0_q};
    assign sel_addr = grant[1] ? addr1 : addr0;
    assign sel_data = grant[1] ? data1 : data0;

    rr_arb2 u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        rf_w_d  = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (clr) begin
            state_d = ST_CLEAR;
            cnt_d   = RADDR_W'(1);
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // cnt wraps to zero after address 31 has been written.
                    if (cnt_q != '0) begin
                        rf_w_d  = 1'b1;
                        waddr_d = cnt_q;
                        wdata_d = '0;
                        cnt_d   = cnt_q + RADDR_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (|grant) begin
                        gnt0_d  = grant[0];
                        gnt1_d  = grant[1];
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                        rf_w_d  = (sel_addr != '0);
                        ptr_d   = grant[0];
                    end
                end
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= RADDR_W'(1);
            ptr_q   <= 1'b0;
            busy_q  <= 1'b1;
            rf_w_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            rf_w_q  <= rf_w_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign busy     = busy_q;
    assign rf_w     = rf_w_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: behavioural reference model compared every
// cycle, directed boundary cases with literal expectations, random traffic.
module tb_regfile_write_ctrl;
    localparam int N = 8;

    logic         clk;
    logic         nReset;
    logic         clr;
    logic         req0, req1;
    logic [4:0]   addr0, addr1;
    logic [N-1:0] data0, data1;
    logic         gnt0, gnt1, busy, rf_w;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    regfile_write_ctrl #(.n(N)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .clr      (clr),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .data0    (data0),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .rf_w     (rf_w),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "clearing" with the next address to wipe, or serving
    // requests; favoured requester flips to the other after every grant.
    bit           m_clearing;
    int           m_next;
    bit           m_fav;
    bit           m_w, m_g0, m_g1;
    logic [4:0]   m_waddr;
    logic [N-1:0] m_wdata;
    bit           m_e0, m_e1;
    int           m_pick;

    assign m_e0   = req0 && !m_g0;
    assign m_e1   = req1 && !m_g1;
    assign m_pick = (m_e0 && m_e1) ? int'(m_fav) : m_e0 ? 0 : m_e1 ? 1 : -1;

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_clearing <= 1'b1;
            m_next     <= 1;
            m_fav      <= 1'b0;
            m_w        <= 1'b0;
            m_g0       <= 1'b0;
            m_g1       <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
        end else begin
            m_w  <= 1'b0;
            m_g0 <= 1'b0;
            m_g1 <= 1'b0;
            if (clr) begin
                m_clearing <= 1'b1;
                m_next     <= 1;
            end else if (m_clearing) begin
                if (m_next <= 31) begin
                    m_w     <= 1'b1;
                    m_waddr <= 5'(m_next);
                    m_wdata <= '0;
                    m_next  <= m_next + 1;
                end else begin
                    m_clearing <= 1'b0;
                end
            end else if (m_pick == 0) begin
                m_g0    <= 1'b1;
                m_waddr <= addr0;
                m_wdata <= data0;
                m_w     <= (addr0 != 0);
                m_fav   <= 1'b1;
            end else if (m_pick == 1) begin
                m_g1    <= 1'b1;
                m_waddr <= addr1;
                m_wdata <= data1;
                m_w     <= (addr1 != 0);
                m_fav   <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic step();
        @(negedge clk);
        chk("gnt0", gnt0, m_g0);
        chk("gnt1", gnt1, m_g1);
        chk("busy", busy, m_clearing);
        chk("rf_w", rf_w, m_w);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("gnt_exclusive", gnt0 & gnt1, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rf_w"}, rf_w, 0);
        chk({tag, "_waddr"}, rf_waddr, 0);
        chk({tag, "_wdata"}, rf_wdata, 0);
        chk({tag, "_gnt"}, {gnt1, gnt0}, 0);
    endtask

    initial begin
        bit found;
        nReset = 1'b0;
        clr = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0;
        data0 = '0; data1 = '0;
        repeat (3) step();
        check_reset_values("reset");

        // Requester 0 waits through the whole clear sequence.
        req0 = 1'b1; addr0 = 5'd5; data0 = 8'hA5;
        nReset = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e <= 31) begin
                chk($sformatf("clr_w_E%0d", e), rf_w, 1);
                chk($sformatf("clr_addr_E%0d", e), rf_waddr, e);
                chk($sformatf("clr_data_E%0d", e), rf_wdata, 0);
                chk($sformatf("clr_busy_E%0d", e), busy, 1);
            end else begin
                chk("busy_off_E32", busy, 0);
                chk("rf_w_off_E32", rf_w, 0);
            end
            chk($sformatf("no_gnt_E%0d", e), gnt0, 0);
        end
        step();
        chk("E33_gnt0", gnt0, 1);
        chk("E33_rf_w", rf_w, 1);
        chk("E33_waddr", rf_waddr, 5);
        chk("E33_wdata", rf_wdata, 8'hA5);
        req0 = 1'b0;
        step();
        chk("idle_gnt0", gnt0, 0);
        chk("idle_rf_w", rf_w, 0);
        chk("idle_hold_waddr", rf_waddr, 5);
        chk("idle_hold_wdata", rf_wdata, 8'hA5);

        // Write to register 0: acknowledged but not written.
        req1 = 1'b1; addr1 = 5'd0; data1 = 8'h3C;
        step();
        chk("r0_gnt1", gnt1, 1);
        chk("r0_rf_w", rf_w, 0);
        req1 = 1'b0;
        step();

        // Both held continuously: alternate starting with requester 0.
        req0 = 1'b1; addr0 = 5'd7; data0 = 8'h11;
        req1 = 1'b1; addr1 = 5'd9; data1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr_gnt0_%0d", k), gnt0, (k % 2 == 0));
            chk($sformatf("rr_gnt1_%0d", k), gnt1, (k % 2 == 1));
            chk($sformatf("rr_addr_%0d", k), rf_waddr, (k % 2 == 0) ? 7 : 9);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // clr beats a pending request; the request is served after the clear.
        clr = 1'b1; req0 = 1'b1; addr0 = 5'd3; data0 = 8'h5A;
        step();
        chk("clr_no_gnt0", gnt0, 0);
        chk("clr_busy", busy, 1);
        clr = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            step();
            chk($sformatf("reclr_addr_%0d", e), rf_waddr, e);
            chk($sformatf("reclr_gnt0_%0d", e), gnt0, 0);
        end
        step();
        chk("reclr_busy_off", busy, 0);
        chk("reclr_gnt0_early", gnt0, 0);
        step();
        chk("reclr_gnt0", gnt0, 1);
        chk("reclr_waddr", rf_waddr, 3);
        req0 = 1'b0;
        step();

        // clr during clear restarts at address 1.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (5) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("restart_addr", rf_waddr, 1);
        chk("restart_w", rf_w, 1);

        // Asynchronous reset once address 11 has been written (cnt=12).
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (rf_w && rf_waddr == 5'd11) found = 1'b1;
            else step();
        end
        chk("reach_cnt12", found, 1);
        #2 nReset = 1'b0;
        #1 check_reset_values("async_rst");
        step();
        step();
        nReset = 1'b1;
        step();
        chk("rst_restart_addr", rf_waddr, 1);
        chk("rst_restart_w", rf_w, 1);

        // Random traffic with occasional clr and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            step();
            clr = ($urandom_range(0, 299) == 0);
            if (!req0 || gnt0) begin
                req0  = ($urandom_range(0, 2) != 0);
                addr0 = 5'($urandom_range(0, 31));
                data0 = N'($urandom);
            end
            if (!req1 || gnt1) begin
                req1  = ($urandom_range(0, 2) != 0);
                addr1 = 5'($urandom_range(0, 31));
                data1 = N'($urandom);
            end
            if ($urandom_range(0, 999) == 0) begin
                #3 nReset = 1'b0;
                step();
                nReset = 1'b1;
            end
        end
        clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_ctrl.md
REGFILE_WRITE_CTRL -- requirements
Module: regfile_write_ctrl

Interface
REQ-001 SHALL have parameter n, default 8, data bus width of the register file it drives.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port nReset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous request to re-run the register clear sequence.
REQ-005 SHALL have ports req0, req1  input  1 each  write request from requester 0 or 1.
REQ-006 SHALL have ports addr0, addr1  input  5 each  destination register of the requester.
REQ-007 SHALL have ports data0, data1  input  n each  write data of the requester.
REQ-008 SHALL have ports gnt0, gnt1  output  1 each  single-cycle acknowledge that the request was taken.
REQ-009 SHALL have port busy  output  1  clear sequence in progress; no grants issued.
REQ-010 SHALL have ports rf_w  output  1, rf_waddr  output  5, rf_wdata  output  n  register-file write port (w, Raddr2, Wdata).

Function
REQ-011 SHALL register all outputs; no combinational path from any input to any output.
REQ-012 SHALL implement FSM states CLEAR and IDLE; CLEAR holds a 5-bit counter cnt.
REQ-013 In CLEAR, each edge SHALL drive rf_w=1, rf_waddr=cnt, rf_wdata=0, then increment cnt; addresses 1..31 are written on consecutive cycles.
REQ-014 After the address-31 write cycle the next edge SHALL set rf_w=0, busy=0, state IDLE.
REQ-015 In IDLE, clr=1 at an edge SHALL enter CLEAR with cnt=1 and busy=1; clr overrides any pending request (no grant at that edge).
REQ-016 clr=1 during CLEAR SHALL restart the sequence at cnt=1.
REQ-017 In IDLE, at each edge, eligible requests SHALL be sampled; a requester is eligible if req is 1 and its gnt is 0 in the current cycle.
REQ-018 One eligible request SHALL be granted per edge: gntX=1, rf_waddr=addrX, rf_wdata=dataX for exactly one cycle; latency request-sampled-edge to gnt/rf_w visible = 1 cycle.
REQ-019 Both eligible SHALL be resolved round-robin: pointer ptr names the favoured requester; after a grant ptr moves to the other requester; a sole eligible requester wins regardless of ptr.
REQ-020 A granted write with addr=0 SHALL assert gnt but hold rf_w=0 (register 0 is hardwired zero).
REQ-021 Requesters SHALL hold req/addr/data stable until gnt; a requester still asserting req in the cycle after gnt presents a new transaction.
REQ-022 With no eligible request, rf_w, gnt0, gnt1 SHALL be 0; rf_waddr/rf_wdata hold their last value.
REQ-023 gnt0 and gnt1 SHALL never be 1 together; no gnt while busy=1.

Reset
REQ-024 While nReset=0: state CLEAR, cnt=1, ptr=0, busy=1, rf_w=0, gnt0=gnt1=0, rf_waddr=0, rf_wdata=0.
REQ-025 The first edge after nReset release (E1) SHALL start the clear: rf_w=1, rf_waddr=1; E31 writes address 31; E32 sets busy=0; E33 is the first edge sampling requests.
REQ-026 Reset asserted mid-clear or mid-grant SHALL immediately force REQ-024 values and restart the full clear on release.

Structure
REQ-027 Package regfile_pkg SHALL hold NREGS=32, RADDR_W=5 and the FSM state enum typedef.
REQ-028 The two-way round-robin decision SHALL be sub-module rr_arb2 (inputs eligible[1:0], ptr; output one-hot grant).

Verification
REQ-029 Reset release -> rf_w=1 on E1..E31 with rf_waddr 1..31, rf_wdata=0; busy=0 from E32; no gnt before E33.
REQ-030 req0 only, addr0=5, data0=8'hA5, sampled at edge k -> gnt0=1, rf_w=1, rf_waddr=5, rf_wdata=8'hA5 for one cycle after k.
REQ-031 req0 and req1 held continuously, ptr=0 -> grants 0,1,0,1 on successive edges; never both; no double write of one transaction.
REQ-032 req1 with addr1=0 -> gnt1=1, rf_w=0.
REQ-033 clr=1 in IDLE with req0 pending -> no gnt0; busy=1; addresses 1..31 cleared; gnt0 on the first sampling edge after busy=0.
REQ-034 nReset pulsed low during clear at cnt=12 -> outputs to reset values; after release clear restarts at address 1.
